debug_mem_dumper: RTL

Debug-unit side master that reads back the data memory through the MEM stage's debug port. On a start pulse it takes over the MEM-stage address and read-control path, sweeps every data-memory word, and filters on the MEM stage's registered dirty bit. Each dirty word is streamed as an address byte followed by four data bytes over a byte valid/ready link to the debug UART transmitter. The sweep ends with a terminator byte. The block sits in the debug unit, between the pipeline's MEM stage and the UART TX.

---
 rtl/debug_mem_dumper_if.sv | 31 +++
 rtl/debug_mem_dumper.sv | 121 ++++++++++++
 2 files changed

// File: rtl/debug_mem_dumper_if.sv
// Debug-memory dump link: MEM-stage debug read port, byte stream to the UART TX, start/busy/done.
// master = dumper side, slave = MEM stage / TX / debug-unit side.
interface debug_mem_dumper_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 7
);
  logic               i_start;
  logic [NB_DATA-1:0] i_mem_data;
  logic               i_bit_sucio;
  logic [NB_ADDR-1:0] o_addr;
  logic               o_ctrl_addr_debug;
  logic               o_ctrl_wr_debug;
  logic               o_read_du;
  logic [7:0]         o_tx_data;
  logic               o_tx_valid;
  logic               i_tx_ready;
  logic               o_busy;
  logic               o_done;

  modport master (
    input  i_start, i_mem_data, i_bit_sucio, i_tx_ready,
    output o_addr, o_ctrl_addr_debug, o_ctrl_wr_debug, o_read_du,
    output o_tx_data, o_tx_valid, o_busy, o_done
  );

  modport slave (
    output i_start, i_mem_data, i_bit_sucio, i_tx_ready,
    input  o_addr, o_ctrl_addr_debug, o_ctrl_wr_debug, o_read_du,
    input  o_tx_data, o_tx_valid, o_busy, o_done
  );
endinterface

// File: rtl/debug_mem_dumper.sv
// Sweeps data memory via the MEM debug port, streams dirty words as addr + 4 data bytes, ends with 0xFF.
// Per word: READ_LAT+2 cycles if clean; SEND stalls with valid/data held while TX is not ready.
module debug_mem_dumper #(
  parameter int NB_DATA   = 32,
  parameter int NB_ADDR   = 7,
  parameter int MEM_DEPTH = 128,
  parameter int READ_LAT  = 2
) (
  input logic                  i_clock,
  input logic                  i_reset,
  debug_mem_dumper_if.master   bus
);
  localparam int WCNT_W = $clog2(READ_LAT + 1);

  typedef enum logic [2:0] {IDLE, WAIT, CHECK, SEND, NEXT, TERM, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [NB_ADDR-1:0] addr;
  logic [2:0]         idx;
  logic [WCNT_W-1:0]  wcnt;
  logic [NB_DATA-1:0] cap_data;
  logic               cap_dirty;

  logic xfer;
  logic wait_last;
  logic addr_last;
  logic [7:0] addr_byte;

  assign xfer      = bus.o_tx_valid && bus.i_tx_ready;
  assign wait_last = (wcnt == WCNT_W'(READ_LAT - 1));
  assign addr_last = (addr == NB_ADDR'(MEM_DEPTH - 1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_start) state_nxt = WAIT;
      WAIT:    if (wait_last) state_nxt = CHECK;
      CHECK:   state_nxt = cap_dirty ? SEND : NEXT;
      SEND:    if (xfer && idx == 3'd4) state_nxt = NEXT;
      NEXT:    state_nxt = addr_last ? TERM : WAIT;
      TERM:    if (xfer) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      addr      <= '0;
      idx       <= '0;
      wcnt      <= '0;
      cap_data  <= '0;
      cap_dirty <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.i_start) begin
          addr <= '0;
          wcnt <= '0;
        end
        WAIT: begin
          wcnt <= wcnt + 1'b1;
          if (wait_last) begin
            cap_data  <= bus.i_mem_data;
            cap_dirty <= bus.i_bit_sucio;
          end
        end
        CHECK: idx <= '0;
        SEND:  if (xfer && idx != 3'd4) idx <= idx + 1'b1;
        // Stay on the last address so o_addr never reaches MEM_DEPTH.
        NEXT: if (!addr_last) begin
          addr <= addr + 1'b1;
          wcnt <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    addr_byte = '0;
    addr_byte[NB_ADDR-1:0] = addr;
  end

  always_comb begin
    bus.o_addr            = addr;
    bus.o_ctrl_addr_debug = 1'b0;
    bus.o_ctrl_wr_debug   = 1'b0;
    bus.o_read_du         = 1'b0;
    bus.o_busy            = 1'b0;
    bus.o_done            = 1'b0;
    bus.o_tx_valid        = 1'b0;
    bus.o_tx_data         = 8'h00;
    if (state != IDLE && state != DONE) begin
      bus.o_ctrl_addr_debug = 1'b1;
      bus.o_ctrl_wr_debug   = 1'b1;
      bus.o_read_du         = 1'b1;
      bus.o_busy            = 1'b1;
    end
    if (state == DONE) bus.o_done = 1'b1;
    if (state == SEND) begin
      bus.o_tx_valid = 1'b1;
      case (idx)
        3'd0:    bus.o_tx_data = addr_byte;
        3'd1:    bus.o_tx_data = cap_data[31:24];
        3'd2:    bus.o_tx_data = cap_data[23:16];
        3'd3:    bus.o_tx_data = cap_data[15:8];
        default: bus.o_tx_data = cap_data[7:0];
      endcase
    end
    if (state == TERM) begin
      bus.o_tx_valid = 1'b1;
      bus.o_tx_data  = 8'hFF;
    end
  end
endmodule
